demux_1x8_slot_sequencer: RTL and testbench

//   Upstream driver for the 1x8 demux. Accepts an 8-bit frame word over a

---
 rtl/demux_1x8_slot_sequencer_if.sv | 26 ++
 rtl/demux_1x8_slot_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_demux_1x8_slot_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1x8_slot_sequencer_if.sv
// Frame handshake between an upstream producer and demux_1x8_slot_sequencer.
//   data_in    : 8-bit frame word, bit k goes to demux output y[k]
//   ch_mask    : channel enable mask, bit k=1 means channel k is visited
//   data_valid : producer has a frame (data_in/ch_mask stable while high)
//   data_ready : sequencer can accept a frame this cycle
// master = producer side, slave = sequencer side.
interface demux_1x8_slot_sequencer_if;
   logic [7:0] data_in;
   logic [7:0] ch_mask;
   logic       data_valid;
   logic       data_ready;

   modport master (
      output data_in,
      output ch_mask,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  ch_mask,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/demux_1x8_slot_sequencer.sv
// Upstream driver for a 1x8 demux. Accepts an 8-bit frame word plus channel
// mask over a valid/ready handshake, then walks the 3-bit select through the
// enabled channels, driving one data bit per channel with en asserted for
// HOLD_CYCLES cycles each. An optional idle gap follows, then a one-cycle
// frame_done pulse.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous reset, active-high
//   up         : frame handshake (slave side)
//   dmx_in     : demux data input
//   dmx_en     : demux enable
//   dmx_s      : demux select
//   busy       : frame in progress
//   frame_done : one-cycle pulse at the end of each frame
// All outputs are registered.
module demux_1x8_slot_sequencer #(
   parameter int HOLD_CYCLES = 1,   // 1..15
   parameter int GAP_CYCLES  = 0,   // 0..15
   parameter bit LSB_FIRST   = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   demux_1x8_slot_sequencer_if.slave        up,
   output logic                             dmx_in,
   output logic                             dmx_en,
   output logic [2:0]                       dmx_s,
   output logic                             busy,
   output logic                             frame_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Counters count down to zero, so they are loaded with length-1.
   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);
   localparam bit         HAS_GAP   = (GAP_CYCLES > 0);

   state_t     state_reg, state_next;
   logic [7:0] data_reg,  data_next;
   logic [7:0] pend_reg,  pend_next;   // enabled channels not yet visited
   logic [2:0] ch_reg,    ch_next;
   logic [3:0] hold_reg,  hold_next;
   logic [3:0] gap_reg,   gap_next;

   logic       dmx_in_reg,     dmx_in_next;
   logic       dmx_en_reg,     dmx_en_next;
   logic [2:0] dmx_s_reg,      dmx_s_next;
   logic       busy_reg,       busy_next;
   logic       frame_done_reg, frame_done_next;
   logic       data_ready_reg, data_ready_next;

   logic [7:0] sel_onehot;

   // First channel in visiting order among the set bits of m. Working from a
   // pending-bit set (rather than incrementing an index) means the walk can
   // never wrap past bit 7 (or bit 0) and masked channels cost nothing.
   function automatic logic [2:0] pick_first(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      if (LSB_FIRST) begin
         for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (m[i]) idx = 3'(i);
         end
      end
      return idx;
   endfunction

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         data_reg  <= 8'd0;
         pend_reg  <= 8'd0;
         ch_reg    <= 3'd0;
         hold_reg  <= 4'd0;
         gap_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         pend_reg  <= pend_next;
         ch_reg    <= ch_next;
         hold_reg  <= hold_next;
         gap_reg   <= gap_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      logic [2:0] first_idx;
      state_next = state_reg;
      data_next  = data_reg;
      pend_next  = pend_reg;
      ch_next    = ch_reg;
      hold_next  = hold_reg;
      gap_next   = gap_reg;
      first_idx  = 3'd0;

      unique case (state_reg)
         IDLE: begin
            // data_ready is high exactly in IDLE, so valid alone means accept.
            if (up.data_valid) begin
               data_next = up.data_in;
               if (up.ch_mask != 8'd0) begin
                  first_idx  = pick_first(up.ch_mask);
                  ch_next    = first_idx;
                  pend_next  = up.ch_mask & ~(8'd1 << first_idx);
                  hold_next  = HOLD_LOAD;
                  state_next = DRIVE;
               end else if (HAS_GAP) begin
                  pend_next  = 8'd0;
                  gap_next   = GAP_LOAD;
                  state_next = GAP;
               end else begin
                  pend_next  = 8'd0;
                  state_next = DONE;
               end
            end
         end

         DRIVE: begin
            if (hold_reg != 4'd0) begin
               hold_next = hold_reg - 4'd1;
            end else if (pend_reg != 8'd0) begin
               first_idx = pick_first(pend_reg);
               ch_next   = first_idx;
               pend_next = pend_reg & ~(8'd1 << first_idx);
               hold_next = HOLD_LOAD;
            end else if (HAS_GAP) begin
               gap_next   = GAP_LOAD;
               state_next = GAP;
            end else begin
               state_next = DONE;
            end
         end

         GAP: begin
            if (gap_reg != 4'd0) begin
               gap_next = gap_reg - 4'd1;
            end else begin
               state_next = DONE;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Per-channel select decode of the channel about to be driven.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_sel
         assign sel_onehot[gi] = (ch_next == 3'(gi));
      end
   endgenerate

   // ---------------- output logic ----------------
   // Outputs are computed from the upcoming state so that, once registered,
   // they line up with the state they describe (first en one cycle after
   // accept).
   always_comb begin
      dmx_en_next     = (state_next == DRIVE);
      dmx_in_next     = (state_next == DRIVE) && ((sel_onehot & data_next) != 8'd0);
      dmx_s_next      = (state_next == DRIVE) ? ch_next : dmx_s_reg;
      busy_next       = (state_next != IDLE);
      frame_done_next = (state_next == DONE);
      data_ready_next = (state_next == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dmx_in_reg     <= 1'b0;
         dmx_en_reg     <= 1'b0;
         dmx_s_reg      <= 3'd0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
         data_ready_reg <= 1'b1;
      end else begin
         dmx_in_reg     <= dmx_in_next;
         dmx_en_reg     <= dmx_en_next;
         dmx_s_reg      <= dmx_s_next;
         busy_reg       <= busy_next;
         frame_done_reg <= frame_done_next;
         data_ready_reg <= data_ready_next;
      end
   end

   assign dmx_in        = dmx_in_reg;
   assign dmx_en        = dmx_en_reg;
   assign dmx_s         = dmx_s_reg;
   assign busy          = busy_reg;
   assign frame_done    = frame_done_reg;
   assign up.data_ready = data_ready_reg;

endmodule

// File: tb/tb_demux_1x8_slot_sequencer.sv
// Directed bench for demux_1x8_slot_sequencer. Three instances cover the
// default parameters (a), HOLD_CYCLES=3/GAP_CYCLES=2 (b) and LSB_FIRST=0 (c).
// Inputs are driven right after a rising edge or at a falling edge; outputs
// are sampled at falling edges.
module tb_demux_1x8_slot_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   demux_1x8_slot_sequencer_if a_if ();
   demux_1x8_slot_sequencer_if b_if ();
   demux_1x8_slot_sequencer_if c_if ();

   logic       a_in, a_en, a_busy, a_fd;
   logic [2:0] a_s;
   logic       b_in, b_en, b_busy, b_fd;
   logic [2:0] b_s;
   logic       c_in, c_en, c_busy, c_fd;
   logic [2:0] c_s;

   demux_1x8_slot_sequencer dut_a (
      .clk(clk), .rst(rst), .up(a_if),
      .dmx_in(a_in), .dmx_en(a_en), .dmx_s(a_s), .busy(a_busy), .frame_done(a_fd)
   );

   demux_1x8_slot_sequencer #(.HOLD_CYCLES(3), .GAP_CYCLES(2), .LSB_FIRST(1'b1)) dut_b (
      .clk(clk), .rst(rst), .up(b_if),
      .dmx_in(b_in), .dmx_en(b_en), .dmx_s(b_s), .busy(b_busy), .frame_done(b_fd)
   );

   demux_1x8_slot_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .LSB_FIRST(1'b0)) dut_c (
      .clk(clk), .rst(rst), .up(c_if),
      .dmx_in(c_in), .dmx_en(c_en), .dmx_s(c_s), .busy(c_busy), .frame_done(c_fd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_a(input logic [7:0] d, input logic [7:0] m);
      a_if.data_in    = d;
      a_if.ch_mask    = m;
      a_if.data_valid = 1'b1;
      @(posedge clk);
      #1;
      a_if.data_valid = 1'b0;
   endtask

   // 1x8 demux model: y[k] = in when en and s==k, else 0.
   function automatic logic [7:0] demux_y(input logic en, input logic din, input logic [2:0] s);
      logic [7:0] y;
      y = en ? (8'(din) << s) : 8'h00;
      return y;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_seq;
      logic [7:0] d;
      logic [7:0] t6_d [4];
      logic [7:0] t6_m [4];
      logic [7:0] cur_d;
      logic [7:0] cur_m;
      logic [7:0] y;
      int         waits;

      a_if.data_in = 8'h00; a_if.ch_mask = 8'h00; a_if.data_valid = 1'b0;
      b_if.data_in = 8'h00; b_if.ch_mask = 8'h00; b_if.data_valid = 1'b0;
      c_if.data_in = 8'h00; c_if.ch_mask = 8'h00; c_if.data_valid = 1'b0;

      // ---- reset state ----
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", a_if.data_ready, 1);
      chk("rst_en",    a_en,   0);
      chk("rst_in",    a_in,   0);
      chk("rst_s",     a_s,    0);
      chk("rst_busy",  a_busy, 0);
      chk("rst_fd",    a_fd,   0);
      rst = 1'b0;
      @(negedge clk);
      $display("reset state checked");

      // ---- A5 / FF, default params ----
      exp_seq = 8'b1010_0101;   // in sequence 1,0,1,0,0,1,0,1 for s=0..7
      chk("t2_ready_pre", a_if.data_ready, 1);
      send_a(8'hA5, 8'hFF);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("t2_en",    a_en, 1);
         chk("t2_s",     a_s, 32'(k));
         chk("t2_in",    a_in, 32'(exp_seq[k]));
         chk("t2_ready", a_if.data_ready, 0);
         chk("t2_fd",    a_fd, 0);
      end
      @(negedge clk);
      chk("t2_done_fd", a_fd, 1);
      chk("t2_done_en", a_en, 0);
      chk("t2_done_in", a_in, 0);
      chk("t2_done_s",  a_s,  7);
      @(negedge clk);
      chk("t2_idle_ready", a_if.data_ready, 1);
      chk("t2_idle_fd",    a_fd,   0);
      chk("t2_idle_busy",  a_busy, 0);
      $display("frame A5/FF checked");

      // ---- sparse mask 81 / data 80 ----
      send_a(8'h80, 8'h81);
      @(negedge clk);
      chk("t3_s0", a_s, 0); chk("t3_in0", a_in, 0); chk("t3_en0", a_en, 1);
      @(negedge clk);
      chk("t3_s7", a_s, 7); chk("t3_in7", a_in, 1); chk("t3_en7", a_en, 1);
      @(negedge clk);
      chk("t3_fd", a_fd, 1); chk("t3_en_done", a_en, 0);
      @(negedge clk);
      chk("t3_ready", a_if.data_ready, 1);
      $display("frame 80/81 checked");

      // ---- empty mask ----
      send_a(8'hFF, 8'h00);
      @(negedge clk);
      chk("t5_fd", a_fd, 1); chk("t5_en", a_en, 0); chk("t5_in", a_in, 0);
      @(negedge clk);
      chk("t5_ready", a_if.data_ready, 1); chk("t5_fd_end", a_fd, 0); chk("t5_en_end", a_en, 0);
      $display("empty-mask frame checked");

      // ---- HOLD=3, GAP=2, mask 04 / data 04 ----
      chk("t4_ready_pre", b_if.data_ready, 1);
      b_if.data_in = 8'h04; b_if.ch_mask = 8'h04; b_if.data_valid = 1'b1;
      @(posedge clk);
      #1;
      b_if.data_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t4_s",  b_s,  2);
         chk("t4_in", b_in, 1);
         chk("t4_en", b_en, 1);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t4_gap_en",   b_en,   0);
         chk("t4_gap_in",   b_in,   0);
         chk("t4_gap_s",    b_s,    2);
         chk("t4_gap_fd",   b_fd,   0);
         chk("t4_gap_busy", b_busy, 1);
      end
      @(negedge clk);
      chk("t4_fd", b_fd, 1);
      @(negedge clk);
      chk("t4_ready", b_if.data_ready, 1);
      $display("hold/gap frame checked");

      // ---- LSB_FIRST=0, mask FF / data 3C ----
      d = 8'h3C;
      c_if.data_in = d; c_if.ch_mask = 8'hFF; c_if.data_valid = 1'b1;
      @(posedge clk);
      #1;
      c_if.data_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("t5c_s",  c_s,  32'(7 - k));
         chk("t5c_in", c_in, 32'(d[7 - k]));
         chk("t5c_en", c_en, 1);
      end
      @(negedge clk);
      chk("t5c_fd", c_fd, 1);
      @(negedge clk);
      chk("t5c_ready", c_if.data_ready, 1);
      $display("msb-first frame checked");

      // ---- reset mid-DRIVE ----
      send_a(8'hA5, 8'hFF);
      repeat (3) @(negedge clk);
      chk("t1_pre_en", a_en, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t1_en",    a_en,   0);
      chk("t1_busy",  a_busy, 0);
      chk("t1_ready", a_if.data_ready, 1);
      chk("t1_fd",    a_fd,   0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t1_post_fd",   a_fd,   0);
         chk("t1_post_busy", a_busy, 0);
      end
      $display("mid-frame reset checked");

      // ---- data_valid held high, alternating frames, demux cross-check ----
      t6_d[0] = 8'h5A; t6_m[0] = 8'h0F;
      t6_d[1] = 8'hC3; t6_m[1] = 8'hF0;
      t6_d[2] = 8'h96; t6_m[2] = 8'h55;
      t6_d[3] = 8'h3C; t6_m[3] = 8'hAA;
      a_if.data_valid = 1'b1;
      for (int f = 0; f < 4; f++) begin
         waits = 0;
         while (!a_if.data_ready && waits < 40) begin
            @(negedge clk);
            waits++;
         end
         chk("t6_ready", a_if.data_ready, 1);
         if (f > 0) chk("t6_wait", 32'(waits), 1);
         cur_d = t6_d[f];
         cur_m = t6_m[f];
         a_if.data_in = cur_d;
         a_if.ch_mask = cur_m;
         @(posedge clk);
         #1;
         // Scrambled inputs while busy must be ignored.
         a_if.data_in = ~cur_d;
         a_if.ch_mask = ~cur_m;
         for (int k = 0; k < 8; k++) begin
            if (cur_m[k]) begin
               @(negedge clk);
               chk("t6_en",    a_en, 1);
               chk("t6_s",     a_s, 32'(k));
               chk("t6_ready_busy", a_if.data_ready, 0);
               y = demux_y(a_en, a_in, a_s);
               chk("t6_y", y, 32'(8'(cur_d[k]) << k));
            end
         end
         @(negedge clk);
         chk("t6_fd", a_fd, 1);
         $display("held-valid frame %0d data=%02h mask=%02h checked", f, cur_d, cur_m);
      end
      a_if.data_valid = 1'b0;
      @(negedge clk);
      chk("t6_end_ready", a_if.data_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
